ps2_host_rx: RTL
================

// Module: ps2_host_rx
// PURPOSE
//  Host-side PS/2 receiver: samples the open-collector ps2_clk/ps2_data lines driven by a
//  device (keyboard/mouse, or our own ps2output core in loopback), de-frames 11-bit frames
//  and presents each byte with a 1-cycle valid strobe. Feeds the UART/bridge side of uart2ps2.
//  Receive-only; never drives the PS/2 lines.
// PARAMETERS
//  CLK_FREQ_HZ   25_000_000  system clock frequency; sets timeout cycle count
//  TIMEOUT_US    200         max gap between falling ps2_clk edges inside a frame
//  FILTER_LEN    8           ps2_clk stability cycles (used only with PS2_RX_FILTER_EN)
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  ps2_clk   in   1  PS/2 clock line (async, idles high)
//  ps2_data  in   1  PS/2 data line (async, idles high)
//  data      out  8  last correctly received byte
//  valid     out  1  1-cycle strobe: data updated this cycle
//  err       out  1  1-cycle strobe: frame rejected (parity/stop/timeout)
//  busy      out  1  high while a frame is in progress (start bit accepted)
// BEHAVIOUR
//  - Reset: data=8'h00, valid=0, err=0, busy=0, state=IDLE, counters cleared. Reset wins over
//    every other event, including mid-frame; partial frame discarded, no err pulse.
//  - Inputs pass 2-FF synchronisers; fall = registered sync_clk 1->0. Pin-to-fall latency
//    3 clk cycles (filter off).
//  - FSM states: IDLE, DATA, PARITY, STOP. Transitions only on fall (except timeout).
//    IDLE: fall with sync_data=0 -> DATA, bit_cnt=0, busy=1; fall with data=1 ignored.
//    DATA: shift sync_data in LSB-first; after 8th bit -> PARITY.
//    PARITY: capture bit -> STOP. Odd parity: ^{byte,parity} must be 1.
//    STOP: sync_data must be 1. Good -> data<=byte, valid=1. Bad parity or stop=0 -> err=1,
//          data unchanged. Either way -> IDLE, busy=0 same cycle as strobe.
//  - valid/err asserted the cycle after the stop-bit fall is detected; never both at once.
//  - Timeout: TIMEOUT_CYC = CLK_FREQ_HZ/1_000_000*TIMEOUT_US; counter cleared on every fall
//    and in IDLE; reaches TIMEOUT_CYC while state!=IDLE -> IDLE, busy=0, err=1 pulse.
//    Fall and timeout in same cycle: fall wins (counter cleared, frame continues).
//  - Counter width $clog2(TIMEOUT_CYC+1); no wrap (saturates at terminal value).
//  - Back-to-back frames: start bit of next frame accepted the cycle after STOP -> IDLE.
// CONFIGURATION
//  PS2_RX_FILTER_EN defined: sync_clk replaced by filtered clock that changes only after the
//    synchronised ps2_clk holds a new level FILTER_LEN consecutive cycles; pulses shorter than
//    FILTER_LEN ignored; pin-to-fall latency 3+FILTER_LEN cycles.
//  Undefined: no filter; every synchronised 1->0 transition is a fall.
// STRUCTURE
//  ps2_pkg: typedef enum logic [1:0] {IDLE,DATA,PARITY,STOP} ps2_rx_state_t; localparams
//    PS2_FRAME_BITS=11, PS2_DATA_BITS=8; odd-parity function shared with ps2output.
//  Sub-module ps2_line_sync: 2-FF sync of clk+data, optional filter, emits sync_data and
//    1-cycle fall pulse. FSM, shifter, timeout counter stay in ps2_host_rx.
// TESTING
//  Bench drives lines at ~12.5 kHz (40 us half period) via a device-model task.
//  1) Frame 0x0B: start0, bits 1,1,0,1,0,0,0,0, parity0, stop1 -> data=8'h0B, valid 1 cycle,
//     err=0, busy high from start fall until strobe.
//  2) Frame 0x00 with parity1 then 0xFF with parity1 back-to-back -> two valid strobes,
//     data 8'h00 then 8'hFF.
//  3) 0x0B with parity forced 1 -> err 1 cycle, valid=0, data keeps previous value.
//  4) 0x0B with stop bit 0 -> err pulse; following good 0xAA frame -> data=8'hAA, valid.
//  5) Stop clocking after 4 data bits; wait > TIMEOUT_CYC -> err pulse, busy=0; next 0x55
//     frame received correctly. Reset asserted mid-frame -> busy=0, no strobes, data=0.
//  6) PS2_RX_FILTER_EN: 2-cycle low glitch on ps2_clk in IDLE with data=0 -> no busy;
//     clean 0x0B frame afterward -> valid, data=8'h0B.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants, receiver state type and odd-parity helper.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS = 8;
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: PS/2 line inputs and received-byte outputs of the host receiver.
interface ps2_host_rx_if;
  import ps2_pkg::*;
  logic ps2_clk;
  logic ps2_data;
  logic [PS2_DATA_BITS-1:0] data;
  logic valid;
  logic err;
  logic busy;
  modport master (output ps2_clk, ps2_data, input data, valid, err, busy);
  modport slave (input ps2_clk, ps2_data, output data, valid, err, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronisers for ps2_clk/ps2_data and registered falling-edge pulse.
// Define PS2_RX_FILTER_EN to debounce ps2_clk over FILTER_LEN stable cycles.
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_data,
  output logic fall
);
  logic [1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic prev_q, prev_d, fall_q, fall_d, sync_data_q, sync_data_d, lvl;
`ifdef PS2_RX_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // level only moves once the synchronised clock has disagreed for FILTER_LEN cycles
  always_comb begin
    filt_d = (clk_sync_q[1] != filt_q && cnt_q == CW'(FILTER_LEN - 1)) ? clk_sync_q[1] : filt_q;
    cnt_d = (clk_sync_q[1] == filt_q || cnt_q == CW'(FILTER_LEN - 1)) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q <= cnt_d;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = clk_sync_q[1];
`endif
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    prev_d = lvl;
    fall_d = prev_q & ~lvl;
    sync_data_d = data_sync_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      data_sync_q <= 2'b11;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      sync_data_q <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      data_sync_q <= data_sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
      sync_data_q <= sync_data_d;
    end
  end
  assign sync_data = sync_data_q;
  assign fall = fall_q;
endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: receive-only PS/2 host; de-frames 11-bit frames into bytes with valid/err strobes.
// Optional ps2_clk glitch filter enabled by defining PS2_RX_FILTER_EN.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input logic clk,
  input logic reset,
  ps2_host_rx_if.slave bus
);
  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ps2_rx_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic sync_data, fall, tmo_hit;
  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk(clk),
    .reset(reset),
    .ps2_clk(bus.ps2_clk),
    .ps2_data(bus.ps2_data),
    .sync_data(sync_data),
    .fall(fall)
  );
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYC);
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    data_d = data_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    tmo_d = (state_q == IDLE || fall) ? '0 : (tmo_hit ? tmo_q : tmo_q + 1'b1);
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = sync_data ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = {sync_data, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = sync_data;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          valid_d = sync_data && par_q == odd_parity(shift_q);
          err_d = !valid_d;
          data_d = valid_d ? shift_q : data_q;
        end
      endcase
    end else if (state_q != IDLE && tmo_hit) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      data_q <= data_d;
      valid_q <= valid_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.data = data_q;
  assign bus.valid = valid_q;
  assign bus.err = err_q;
  assign bus.busy = state_q != IDLE;
endmodule
